alu_arbiter: RTL

Two-port round-robin arbiter and sequencer that shares the single combinational 32-bit ALU between two requesters, e.g. the main datapath and a debug/self-test port. It accepts one operation at a time through a valid/ready handshake and drives the ALU from registered operands. It captures the ALU result and compare flags into a holding register and returns them to the winning requester through a second valid/ready handshake. It sits between the requesters and the ALU instance; the ALU itself is unchanged.

---
 rtl/alu_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter/sequencer in front of a shared
// combinational 32-bit ALU. It accepts one operation at a time, drives the ALU
// from registered operands, captures the result and compare flags, then hands
// them back to the requester that issued the operation.
module alu_arbiter #(
    parameter bit FIXED_PRIO = 1'b0   // 0: round-robin, 1: port 0 always wins
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [4:0]  req0_shamt,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [4:0]  req1_shamt,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic [1:0]  rsp_cmp,

    output logic        busy,

    output logic [2:0]  alu_ctrl,
    output logic [4:0]  alu_shift,
    output logic [31:0] alu_srca,
    output logic [31:0] alu_srcb,
    input  logic [31:0] alu_result,
    input  logic [1:0]  alu_cmp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [2:0]  op_q;
    logic [4:0]  shamt_q;
    logic [31:0] a_q, b_q;
    logic        owner_q;
    logic        last_q;
    logic [31:0] res_q;
    logic [1:0]  cmp_q;

    logic        gnt_port;   // port that wins arbitration this cycle
    logic        accept;     // an operation is taken on this edge
    logic        consume;    // the owner takes the response on this edge

    // Grant selection and handshake qualifiers.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        gnt_port = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_port = FIXED_PRIO ? 1'b0 : ~last_q;
        end else if (req1_valid) begin
            gnt_port = 1'b1;
        end
        accept  = (state_q == IDLE) && (req0_valid || req1_valid);
        consume = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept -> one execute cycle -> hold response until consumed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)  state_d = EXEC;
            EXEC:                 state_d = RESP;
            RESP:    if (consume) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = (state_q != IDLE);
        if (state_q == IDLE) begin
            req0_ready = req0_valid && !gnt_port;
            req1_ready = req1_valid &&  gnt_port;
        end
        if (state_q == RESP) begin
            rsp0_valid = !owner_q;
            rsp1_valid =  owner_q;
        end
    end

    // Operand capture on accept, result capture in EXEC, last-served update on consume.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= '0;
            shamt_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;   // port 0 wins the first contention
            res_q   <= '0;
            cmp_q   <= '0;
        end else begin
            if (accept) begin
                op_q    <= gnt_port ? req1_op    : req0_op;
                shamt_q <= gnt_port ? req1_shamt : req0_shamt;
                a_q     <= gnt_port ? req1_a     : req0_a;
                b_q     <= gnt_port ? req1_b     : req0_b;
                owner_q <= gnt_port;
            end
            if (state_q == EXEC) begin
                res_q <= alu_result;
                cmp_q <= alu_cmp;
            end
            if (consume) begin
                last_q <= owner_q;
            end
        end
    end

    // The ALU always sees the registered operation; responses always show the holding register.
    assign alu_ctrl   = op_q;
    assign alu_shift  = shamt_q;
    assign alu_srca   = a_q;
    assign alu_srcb   = b_q;
    assign rsp_result = res_q;
    assign rsp_cmp    = cmp_q;

endmodule
